// File: rtl/if_id_stage.sv
// Instruction-fetch front end of the 5-stage RISC-V core: the PC register, the IF/ID
// pipeline register, and saturating stall/flush counters for performance debug.
module if_id_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             PCWrite_i,
    input  logic             Stall_i,
    input  logic             Flush_i,
    input  logic [XLEN-1:0]  branch_target_i,
    input  logic [XLEN-1:0]  imem_instr_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  ID_pc_o,
    output logic [XLEN-1:0]  ID_instr_o,
    output logic             ID_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             flush_eff;
    logic [XLEN-1:0]  pc_q,        pc_d;
    logic [XLEN-1:0]  id_pc_q,     id_pc_d;
    logic [XLEN-1:0]  id_instr_q,  id_instr_d;
    logic             id_valid_q,  id_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // A branch whose operands are still stalled is unresolved, so Stall_i masks Flush_i.
    assign flush_eff = Flush_i & ~Stall_i;

    always_comb begin
        pc_d = pc_q;
        if (PCWrite_i) begin
            if (flush_eff) begin
                pc_d = {branch_target_i[XLEN-1:2], 2'b00};
            end else begin
                pc_d = pc_q + PC_STEP;
            end
        end
    end

    always_comb begin
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        if (!Stall_i) begin
            if (flush_eff) begin
                id_pc_d    = '0;
                id_instr_d = '0;
                id_valid_d = 1'b0;
            end else begin
                id_pc_d    = pc_q;
                id_instr_d = imem_instr_i;
                id_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Stall_i && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_eff && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q        <= RESET_PC;
            id_pc_q     <= '0;
            id_instr_q  <= '0;
            id_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            id_pc_q     <= id_pc_d;
            id_instr_q  <= id_instr_d;
            id_valid_q  <= id_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_o        = pc_q;
    assign ID_pc_o     = id_pc_q;
    assign ID_instr_o  = id_instr_q;
    assign ID_valid_o  = id_valid_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed fetch/stall/flush scenarios, randomized
// traffic against a behavioural pipeline model, PC wrap and counter saturation.
module tb_if_id_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance (default parameters)
    logic        rst, pcw, stall, flush, use_const;
    logic [31:0] tgt, imem, pc, id_pc, id_instr, stall_cnt, flush_cnt;
    logic        id_valid;

    // Auxiliary instances share one input set: wrapping reset PC and 2-bit counters
    logic        a_rst, a_pcw, a_stall, a_flush;
    logic [31:0] a_tgt, w_imem, s_imem;
    logic [31:0] w_pc, w_id_pc, w_id_instr, w_stall_cnt, w_flush_cnt;
    logic [31:0] s_pc, s_id_pc, s_id_instr;
    logic        w_id_valid, s_id_valid;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    function automatic logic [31:0] imem_of(input logic [31:0] a, input logic c);
        return c ? 32'h0000_0093 : ((a ^ 32'hA5A5_0000) + 32'h0000_0013);
    endfunction

    assign imem   = imem_of(pc, use_const);
    assign w_imem = imem_of(w_pc, 1'b0);
    assign s_imem = imem_of(s_pc, 1'b0);

    if_id_stage dut (
        .clk_i(clk), .rst_i(rst), .PCWrite_i(pcw), .Stall_i(stall), .Flush_i(flush),
        .branch_target_i(tgt), .imem_instr_i(imem), .pc_o(pc), .ID_pc_o(id_pc),
        .ID_instr_o(id_instr), .ID_valid_o(id_valid), .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt)
    );

    if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_i(a_rst), .PCWrite_i(a_pcw), .Stall_i(a_stall), .Flush_i(a_flush),
        .branch_target_i(a_tgt), .imem_instr_i(w_imem), .pc_o(w_pc), .ID_pc_o(w_id_pc),
        .ID_instr_o(w_id_instr), .ID_valid_o(w_id_valid), .stall_cnt_o(w_stall_cnt),
        .flush_cnt_o(w_flush_cnt)
    );

    if_id_stage #(.CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(a_rst), .PCWrite_i(a_pcw), .Stall_i(a_stall), .Flush_i(a_flush),
        .branch_target_i(a_tgt), .imem_instr_i(s_imem), .pc_o(s_pc), .ID_pc_o(s_id_pc),
        .ID_instr_o(s_id_instr), .ID_valid_o(s_id_valid), .stall_cnt_o(s_stall_cnt),
        .flush_cnt_o(s_flush_cnt)
    );

    // Behavioural model of the main instance: architectural state of fetch + ID slot
    logic [31:0] m_pc, m_id_pc, m_id_instr, m_stall_cnt, m_flush_cnt;
    logic        m_id_valid;

    task automatic model_reset();
        m_pc = 32'h0; m_id_pc = 32'h0; m_id_instr = 32'h0; m_id_valid = 1'b0;
        m_stall_cnt = 32'h0; m_flush_cnt = 32'h0;
    endtask

    // One clock edge: the model advances from the inputs held across the edge
    task automatic tick();
        logic        taken;
        logic [31:0] n_pc, n_id_pc, n_id_instr, n_sc, n_fc;
        logic        n_id_valid;
        taken = flush && !stall;
        n_pc = m_pc; n_id_pc = m_id_pc; n_id_instr = m_id_instr; n_id_valid = m_id_valid;
        n_sc = m_stall_cnt; n_fc = m_flush_cnt;
        if (rst) begin
            if (pcw) n_pc = taken ? (tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
            if (!stall) begin
                n_id_pc    = taken ? 32'h0 : m_pc;
                n_id_instr = taken ? 32'h0 : imem_of(m_pc, use_const);
                n_id_valid = !taken;
            end
            if (stall && m_stall_cnt != 32'hFFFF_FFFF) n_sc = m_stall_cnt + 1;
            if (taken && m_flush_cnt != 32'hFFFF_FFFF) n_fc = m_flush_cnt + 1;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_id_pc = n_id_pc; m_id_instr = n_id_instr; m_id_valid = n_id_valid;
        m_stall_cnt = n_sc; m_flush_cnt = n_fc;
    endtask

    task automatic drive(input logic p, input logic s, input logic f, input logic [31:0] t);
        pcw = p; stall = s; flush = f; tgt = t;
    endtask

    task automatic test_reset();
        rst = 1'b0; use_const = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        model_reset();
        tick();
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got %h expected %h", pc, 32'h0); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_id_pc got %h expected %h", id_pc, 32'h0); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_id_instr got %h expected %h", id_instr, 32'h0); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_valid got %b expected 0", id_valid); end
        checks++; if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin errors++; $display("[TB] FAIL reset_counters got %h/%h expected 0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_fetch();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (pc !== 32'h0C) begin errors++; $display("[TB] FAIL fetch_pc got %h expected %h", pc, 32'h0C); end
        checks++; if (id_pc !== 32'h08) begin errors++; $display("[TB] FAIL fetch_id_pc got %h expected %h", id_pc, 32'h08); end
        checks++; if (id_valid !== 1'b1 || id_instr !== 32'h93) begin errors++; $display("[TB] FAIL fetch_id got valid=%b instr=%h expected 1/00000093", id_valid, id_instr); end
        checks++; if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin errors++; $display("[TB] FAIL fetch_counters got %h/%h expected 0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_stall();
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (pc !== 32'h10 || id_pc !== 32'h0C) begin errors++; $display("[TB] FAIL stall_hold got pc=%h id_pc=%h expected 10/0c", pc, id_pc); end
        checks++; if (stall_cnt !== 32'h1) begin errors++; $display("[TB] FAIL stall_cnt got %h expected 1", stall_cnt); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checks++; if (pc !== 32'h14 || id_pc !== 32'h10) begin errors++; $display("[TB] FAIL stall_release got pc=%h id_pc=%h expected 14/10", pc, id_pc); end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 1'b1, 32'h43);
        tick();
        checks++; if (pc !== 32'h40) begin errors++; $display("[TB] FAIL flush_pc got %h expected 40", pc); end
        checks++; if (id_instr !== 32'h0 || id_valid !== 1'b0 || id_pc !== 32'h0) begin errors++; $display("[TB] FAIL flush_bubble got pc=%h instr=%h valid=%b expected 0/0/0", id_pc, id_instr, id_valid); end
        checks++; if (flush_cnt !== 32'h1) begin errors++; $display("[TB] FAIL flush_cnt got %h expected 1", flush_cnt); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checks++; if (id_pc !== 32'h40 || id_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_target_in_id got pc=%h valid=%b expected 40/1", id_pc, id_valid); end
    endtask

    task automatic test_stall_beats_flush();
        logic [31:0] pc0, idpc0, idi0, sc0, fc0;
        logic        idv0;
        pc0 = pc; idpc0 = id_pc; idi0 = id_instr; idv0 = id_valid; sc0 = stall_cnt; fc0 = flush_cnt;
        drive(1'b0, 1'b1, 1'b1, 32'h100);
        tick();
        checks++; if (pc !== pc0 || id_pc !== idpc0 || id_instr !== idi0 || id_valid !== idv0) begin errors++; $display("[TB] FAIL stall_flush_hold got pc=%h id_pc=%h expected %h/%h", pc, id_pc, pc0, idpc0); end
        checks++; if (flush_cnt !== fc0) begin errors++; $display("[TB] FAIL stall_flush_fcnt got %h expected %h", flush_cnt, fc0); end
        checks++; if (stall_cnt !== sc0 + 32'd1) begin errors++; $display("[TB] FAIL stall_flush_scnt got %h expected %h", stall_cnt, sc0 + 32'd1); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_random();
        use_const = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 5) == 0, $urandom);
            tick();
            checks++; if (pc !== m_pc) begin errors++; $display("[TB] FAIL rand_pc cycle %0d got %h expected %h", i, pc, m_pc); end
            checks++; if (id_pc !== m_id_pc) begin errors++; $display("[TB] FAIL rand_id_pc cycle %0d got %h expected %h", i, id_pc, m_id_pc); end
            checks++; if (id_instr !== m_id_instr) begin errors++; $display("[TB] FAIL rand_id_instr cycle %0d got %h expected %h", i, id_instr, m_id_instr); end
            checks++; if (id_valid !== m_id_valid) begin errors++; $display("[TB] FAIL rand_id_valid cycle %0d got %b expected %b", i, id_valid, m_id_valid); end
            checks++; if (stall_cnt !== m_stall_cnt) begin errors++; $display("[TB] FAIL rand_stall_cnt cycle %0d got %h expected %h", i, stall_cnt, m_stall_cnt); end
            checks++; if (flush_cnt !== m_flush_cnt) begin errors++; $display("[TB] FAIL rand_flush_cnt cycle %0d got %h expected %h", i, flush_cnt, m_flush_cnt); end
        end
    endtask

    task automatic test_pc_wrap();
        a_rst = 1'b0; a_pcw = 1'b1; a_stall = 1'b0; a_flush = 1'b0; a_tgt = 32'h0;
        @(posedge clk); #1;
        checks++; if (w_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_reset_pc got %h expected fffffffc", w_pc); end
        a_rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (w_pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc got %h expected 0", w_pc); end
        checks++; if (w_id_pc !== 32'hFFFF_FFFC || w_id_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_id got pc=%h valid=%b expected fffffffc/1", w_id_pc, w_id_valid); end
    endtask

    task automatic test_saturation();
        a_stall = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        checks++; if (s_stall_cnt !== 2'd3) begin errors++; $display("[TB] FAIL sat_stall_cnt got %0d expected 3", s_stall_cnt); end
        a_stall = 1'b0; a_flush = 1'b1; a_tgt = 32'h200;
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (s_flush_cnt !== 2'd3) begin errors++; $display("[TB] FAIL sat_flush_cnt got %0d expected 3", s_flush_cnt); end
        a_flush = 1'b0;
        @(posedge clk); #1;
        #2 a_rst = 1'b0;
        #1;
        checks++; if (s_pc !== 32'h0 || s_id_pc !== 32'h0 || s_id_instr !== 32'h0 || s_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_pipe got pc=%h id_pc=%h instr=%h valid=%b expected all 0", s_pc, s_id_pc, s_id_instr, s_id_valid); end
        checks++; if (s_stall_cnt !== 2'd0 || s_flush_cnt !== 2'd0) begin errors++; $display("[TB] FAIL async_reset_cnt got %0d/%0d expected 0/0", s_stall_cnt, s_flush_cnt); end
        checks++; if (w_pc !== 32'hFFFF_FFFC || w_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_wrap got pc=%h valid=%b expected fffffffc/0", w_pc, w_id_valid); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_flush();
        test_stall_beats_flush();
        test_random();
        test_pc_wrap();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
